// File: rtl/mask_unit_resp_pkg.sv
// Shared types and constants for the mask unit read-response crossbar.
// Optional feature macro: MASK_UNIT_RESP_PERF_EN (conflict counters).
package mask_unit_resp_pkg;

  function automatic int LANE_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int RESP_LANES  = 4;
  localparam int RESP_DATA_W = 32;
  localparam int RESP_IDX_W  = LANE_IDX_W(RESP_LANES);
  localparam int RESP_OFF_W  = 2;
  localparam int PERF_CNT_W  = 16;

  typedef struct packed {
    logic [RESP_DATA_W-1:0] data;
    logic [RESP_IDX_W-1:0]  writeIndex;
    logic [RESP_OFF_W-1:0]  dataOffset;
  } resp_entry_t;

endpackage

// File: rtl/mask_unit_resp_fifo.sv
// Per-lane response buffer: count-based full/empty, head visible
// combinationally, synchronous active-low reset.
module mask_unit_resp_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pushValid,
  output logic         pushReady,
  input  logic [W-1:0] pushData,
  input  logic         popEn,
  output logic         headValid,
  output logic [W-1:0] headData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  assign pushReady = count < CW'(DEPTH);
  assign headValid = count != '0;
  assign headData  = mem[rdPtr];
  assign doPush    = pushValid & pushReady;
  assign doPop     = popEn & headValid;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/mask_unit_read_resp_crossbar.sv
// Lane read-response return crossbar with per-requester round-robin.
// Optional feature macro: MASK_UNIT_RESP_PERF_EN (conflict_cnt port).
module mask_unit_read_resp_crossbar
  import mask_unit_resp_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [LANES-1:0]                     lane_valid,
  output logic [LANES-1:0]                     lane_ready,
  input  logic [LANES*DATA_W-1:0]              lane_data,
  input  logic [LANES*LANE_IDX_W(LANES)-1:0]   lane_writeIndex,
  input  logic [LANES*2-1:0]                   lane_dataOffset,
  output logic [LANES-1:0]                     req_valid,
  input  logic [LANES-1:0]                     req_ready,
  output logic [LANES*DATA_W-1:0]              req_data,
  output logic [LANES*2-1:0]                   req_dataOffset,
  output logic [LANES*LANE_IDX_W(LANES)-1:0]   req_srcLane
`ifdef MASK_UNIT_RESP_PERF_EN
  ,
  output logic [LANES*PERF_CNT_W-1:0]          conflict_cnt
`endif
);

  localparam int IDX_W = LANE_IDX_W(LANES);
  localparam int OFF_W = 2;
  localparam int EW    = DATA_W + IDX_W + OFF_W;

  logic [EW-1:0]    headData [LANES];
  logic [IDX_W-1:0] headIdx  [LANES];
  logic [LANES-1:0] headValid;
  logic [LANES-1:0] popEn;
  logic [LANES-1:0] popMat   [LANES];

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [EW-1:0] pushData;

    assign pushData = {
      lane_data[i*DATA_W +: DATA_W],
      lane_writeIndex[i*IDX_W +: IDX_W],
      lane_dataOffset[i*OFF_W +: OFF_W]
    };

    mask_unit_resp_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
    ) uFifo (
      .clock     (clock),
      .reset     (reset),
      .pushValid (lane_valid[i]),
      .pushReady (lane_ready[i]),
      .pushData  (pushData),
      .popEn     (popEn[i]),
      .headValid (headValid[i]),
      .headData  (headData[i])
    );

    assign headIdx[i] = headData[i][OFF_W +: IDX_W];
  end

  // Each lane head targets one requester, so OR-ing pops is safe.
  always_comb begin
    popEn = '0;
    for (int r = 0; r < LANES; r++) begin
      for (int i = 0; i < LANES; i++) begin
        popEn[i] = popEn[i] | popMat[r][i];
      end
    end
  end

  for (genvar r = 0; r < LANES; r++) begin : gReq
    logic [LANES-1:0] cand;
    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] grantIdx;
    logic             anyCand;
    logic             fire;

    // Lanes whose head is addressed to this requester.
    always_comb begin
      cand = '0;
      for (int i = 0; i < LANES; i++) begin
        cand[i] = headValid[i] && (headIdx[i] == IDX_W'(r));
      end
    end

    // Round-robin search starting at rrPtr, wrapping mod LANES.
    always_comb begin
      logic [IDX_W-1:0] idx;
      idx      = '0;
      anyCand  = 1'b0;
      grantIdx = rrPtr;
      for (int k = 0; k < LANES; k++) begin
        idx = rrPtr + IDX_W'(k);
        if (!anyCand && cand[idx]) begin
          anyCand  = 1'b1;
          grantIdx = idx;
        end
      end
    end

    assign fire      = anyCand & req_ready[r];
    assign popMat[r] = fire ? (LANES'(1) << grantIdx) : '0;
    assign req_valid[r] = anyCand;

    assign req_data[r*DATA_W +: DATA_W] = anyCand ?
      headData[grantIdx][OFF_W+IDX_W +: DATA_W] : '0;
    assign req_dataOffset[r*OFF_W +: OFF_W] = anyCand ?
      headData[grantIdx][0 +: OFF_W] : '0;
    assign req_srcLane[r*IDX_W +: IDX_W] = anyCand ?
      grantIdx : '0;

    // Advance priority past the lane just served.
    always_ff @(posedge clock) begin
      if (!reset) begin
        rrPtr <= '0;
      end else if (fire) begin
        rrPtr <= grantIdx + 1'b1;
      end
    end

`ifdef MASK_UNIT_RESP_PERF_EN
    logic [PERF_CNT_W-1:0] confCnt;

    // Saturating count of cycles with contending lanes.
    always_ff @(posedge clock) begin
      if (!reset) begin
        confCnt <= '0;
      end else if (($countones(cand) > 1) && (confCnt != '1)) begin
        confCnt <= confCnt + 1'b1;
      end
    end

    assign conflict_cnt[r*PERF_CNT_W +: PERF_CNT_W] = confCnt;
`endif
  end

endmodule

// File: tb/tb_mask_unit_read_resp_crossbar.sv
// Directed self-checking bench for mask_unit_read_resp_crossbar.
// Covers reset, routing, conflicts, backpressure, full rate, mid reset.
module tb_mask_unit_read_resp_crossbar;

  logic         clock;
  logic         reset;
  logic [3:0]   lane_valid;
  logic [3:0]   lane_ready;
  logic [127:0] lane_data;
  logic [7:0]   lane_writeIndex;
  logic [7:0]   lane_dataOffset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [7:0]   req_dataOffset;
  logic [7:0]   req_srcLane;
`ifdef MASK_UNIT_RESP_PERF_EN
  logic [63:0]  conflict_cnt;
`endif

  int pass;
  int total;

  mask_unit_read_resp_crossbar dut (
    .clock           (clock),
    .reset           (reset),
    .lane_valid      (lane_valid),
    .lane_ready      (lane_ready),
    .lane_data       (lane_data),
    .lane_writeIndex (lane_writeIndex),
    .lane_dataOffset (lane_dataOffset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_dataOffset  (req_dataOffset),
    .req_srcLane     (req_srcLane)
`ifdef MASK_UNIT_RESP_PERF_EN
    ,
    .conflict_cnt    (conflict_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic setLane(input int i, input logic [31:0] d,
                         input logic [1:0] w, input logic [1:0] o);
    lane_valid[i]            = 1'b1;
    lane_data[i*32 +: 32]    = d;
    lane_writeIndex[i*2 +: 2] = w;
    lane_dataOffset[i*2 +: 2] = o;
  endtask

  function automatic logic [31:0] xdata(input int i, input int c);
    return (32'(i) << 24) | (32'(c) << 16) | 32'h5A5A;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    lane_valid = 4'hF;
    lane_data = {4{32'hDEAD_BEEF}};
    lane_writeIndex = 8'hE4;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    lane_valid = 4'h0;
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL reset_req_valid got %b want 0000", req_valid);
    else pass++;
    total++;
    if (lane_ready !== 4'b1111)
      $display("FAIL reset_lane_ready got %b want 1111", lane_ready);
    else pass++;
    total++;
    if (req_data !== 128'd0)
      $display("FAIL reset_req_data got %h want 0", req_data);
    else pass++;
    step();
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL reset_idle_valid got %b want 0000", req_valid);
    else pass++;
  endtask

  task automatic test_single();
    req_ready = 4'b0000;
    setLane(2, 32'hA5A5_0001, 2'd1, 2'd2);
    step();
    lane_valid = 4'h0;
    total++;
    if (req_valid !== 4'b0010)
      $display("FAIL single_valid got %b want 0010", req_valid);
    else pass++;
    total++;
    if (req_data[63:32] !== 32'hA5A5_0001)
      $display("FAIL single_data got %h want a5a50001", req_data[63:32]);
    else pass++;
    total++;
    if (req_srcLane[3:2] !== 2'd2)
      $display("FAIL single_src got %0d want 2", req_srcLane[3:2]);
    else pass++;
    total++;
    if (req_dataOffset[3:2] !== 2'd2)
      $display("FAIL single_off got %0d want 2", req_dataOffset[3:2]);
    else pass++;
    req_ready = 4'b0010;
    step();
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL single_drain got %b want 0000", req_valid);
    else pass++;
    req_ready = 4'b0000;
  endtask

  task automatic test_conflict();
    req_ready = 4'hF;
    for (int i = 0; i < 4; i++)
      setLane(i, 32'hC0DE_0000 + 32'(i), 2'd0, 2'(i));
    step();
    lane_valid = 4'h0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (req_valid !== 4'b0001)
        $display("FAIL conflict_valid%0d got %b want 0001", k, req_valid);
      else pass++;
      total++;
      if (req_srcLane[1:0] !== 2'(k))
        $display("FAIL conflict_src%0d got %0d want %0d",
                 k, req_srcLane[1:0], k);
      else pass++;
      total++;
      if (req_data[31:0] !== 32'hC0DE_0000 + 32'(k))
        $display("FAIL conflict_data%0d got %h want %h",
                 k, req_data[31:0], 32'hC0DE_0000 + 32'(k));
      else pass++;
      step();
    end
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL conflict_drain got %b want 0000", req_valid);
    else pass++;
`ifdef MASK_UNIT_RESP_PERF_EN
    total++;
    if (conflict_cnt[15:0] !== 16'd3)
      $display("FAIL conflict_cnt got %0d want 3", conflict_cnt[15:0]);
    else pass++;
`endif
    req_ready = 4'h0;
  endtask

  task automatic test_backpressure();
    req_ready = 4'b0000;
    setLane(1, 32'hB000_0000, 2'd2, 2'd1);
    step();
    setLane(1, 32'hB000_0001, 2'd2, 2'd1);
    step();
    setLane(1, 32'hB000_0002, 2'd2, 2'd3);
    total++;
    if (lane_ready[1] !== 1'b0)
      $display("FAIL bp_full got %b want 0", lane_ready[1]);
    else pass++;
    total++;
    if (req_valid !== 4'b0100 || req_data[95:64] !== 32'hB000_0000)
      $display("FAIL bp_head got %b/%h want 0100/b0000000",
               req_valid, req_data[95:64]);
    else pass++;
    step();
    total++;
    if (lane_ready[1] !== 1'b0 || req_data[95:64] !== 32'hB000_0000)
      $display("FAIL bp_hold got %b/%h want 0/b0000000",
               lane_ready[1], req_data[95:64]);
    else pass++;
    req_ready = 4'b0100;
    total++;
    if (lane_ready[1] !== 1'b0)
      $display("FAIL bp_nobypass got %b want 0", lane_ready[1]);
    else pass++;
    step();
    total++;
    if (lane_ready[1] !== 1'b1 || req_data[95:64] !== 32'hB000_0001)
      $display("FAIL bp_second got %b/%h want 1/b0000001",
               lane_ready[1], req_data[95:64]);
    else pass++;
    step();
    lane_valid = 4'h0;
    total++;
    if (req_valid !== 4'b0100 || req_data[95:64] !== 32'hB000_0002)
      $display("FAIL bp_third got %b/%h want 0100/b0000002",
               req_valid, req_data[95:64]);
    else pass++;
    total++;
    if (req_dataOffset[5:4] !== 2'd3)
      $display("FAIL bp_off got %0d want 3", req_dataOffset[5:4]);
    else pass++;
    step();
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL bp_drain got %b want 0000", req_valid);
    else pass++;
    req_ready = 4'b0000;
  endtask

  task automatic test_full_crossbar();
    int r;
    req_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++)
        setLane(i, xdata(i, c), 2'((i + 1) % 4), 2'(c % 4));
      if (c > 0) begin
        total++;
        if (req_valid !== 4'hF || lane_ready !== 4'hF)
          $display("FAIL xbar_rate%0d got %b/%b want 1111/1111",
                   c, req_valid, lane_ready);
        else pass++;
        for (int i = 0; i < 4; i++) begin
          r = (i + 1) % 4;
          total++;
          if (req_data[r*32 +: 32] !== xdata(i, c - 1) ||
              req_srcLane[r*2 +: 2] !== 2'(i))
            $display("FAIL xbar_route%0d_%0d got %h/%0d want %h/%0d",
                     c, r, req_data[r*32 +: 32], req_srcLane[r*2 +: 2],
                     xdata(i, c - 1), i);
          else pass++;
        end
      end
      step();
    end
    lane_valid = 4'h0;
    total++;
    if (req_valid !== 4'hF || req_data[31:0] !== xdata(3, 5))
      $display("FAIL xbar_last got %b/%h want 1111/%h",
               req_valid, req_data[31:0], xdata(3, 5));
    else pass++;
    step();
    total++;
    if (req_valid !== 4'b0000)
      $display("FAIL xbar_drain got %b want 0000", req_valid);
    else pass++;
    req_ready = 4'h0;
  endtask

  task automatic test_reset_mid();
    req_ready = 4'b0000;
    setLane(3, 32'hE000_0000, 2'd0, 2'd3);
    step();
    setLane(3, 32'hE000_0001, 2'd0, 2'd3);
    step();
    lane_valid = 4'h0;
    total++;
    if (req_valid !== 4'b0001 || req_srcLane[1:0] !== 2'd3)
      $display("FAIL mid_pre got %b/%0d want 0001/3",
               req_valid, req_srcLane[1:0]);
    else pass++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (req_valid !== 4'b0000 || lane_ready !== 4'hF)
      $display("FAIL mid_post got %b/%b want 0000/1111",
               req_valid, lane_ready);
    else pass++;
    total++;
    if (req_data !== 128'd0)
      $display("FAIL mid_data got %h want 0", req_data);
    else pass++;
    req_ready = 4'hF;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (req_valid !== 4'b0000)
        $display("FAIL mid_stale%0d got %b want 0000", k, req_valid);
      else pass++;
    end
  endtask

  initial begin
    pass            = 0;
    total           = 0;
    reset           = 1'b0;
    lane_valid      = 4'h0;
    lane_data       = '0;
    lane_writeIndex = '0;
    lane_dataOffset = '0;
    req_ready       = 4'h0;
    test_reset();
    test_single();
    test_conflict();
    test_backpressure();
    test_full_crossbar();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/mask_unit_read_resp_crossbar.md
# mask_unit_read_resp_crossbar

Return-path crossbar of the mask unit's lane-read network. Accepts read-data responses from LANES lane ports, each tagged with the `writeIndex` the request crossbar attached, and buffers them per lane. It then routes each response back to the requester port `writeIndex`, using round-robin arbitration when several lanes target the same requester in one cycle. It sits between the lane read-data outputs and the mask unit's per-requester data collectors.

## Interface
- `LANES`, 4: lane/requester count; power of two, ≥2.
- `DATA_W`, 32: read-data width.
- `FIFO_DEPTH`, 2: per-lane response buffer entries; power of two, ≥2.
- `IDX_W`, $clog2(LANES): width of index fields (derived, not overridable).

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on `clock`.
- `lane_valid`  in  LANES  lane i has a response.
- `lane_ready`  out  LANES  lane i FIFO can accept.
- `lane_data`  in  LANES*DATA_W  response data, lane i at [i*DATA_W +: DATA_W].
- `lane_writeIndex`  in  LANES*IDX_W  destination requester of lane i response.
- `lane_dataOffset`  in  LANES*2  data offset echoed from the request.
- `req_valid`  out  LANES  response available for requester r.
- `req_ready`  in  LANES  requester r accepts.
- `req_data`  out  LANES*DATA_W  data for requester r.
- `req_dataOffset`  out  LANES*2  echoed offset.
- `req_srcLane`  out  LANES*IDX_W  lane the response came from.

## Operation
- Per lane: FIFO of `{data, writeIndex, dataOffset}`.
  - Push on `lane_valid[i] & lane_ready[i]`.
  - `lane_ready[i]` = count < FIFO_DEPTH, from registered count only; no dependence on `req_ready`.
- Head candidate: lane i requests requester r when its FIFO is non-empty and head.writeIndex == r.
- Per requester r: round-robin arbiter over lane candidates.
  - Registered pointer `rr[r]` (IDX_W bits); priority starts at `rr[r]` and wraps modulo LANES.
  - Grant is combinational from FIFO heads and `rr[r]`.
  - `req_valid[r]` = any candidate. Data, offset and srcLane come from the granted head.
- On `req_valid[r] & req_ready[r]`: pop the granted lane's FIFO and set `rr[r]` to granted lane + 1 (mod LANES). With no handshake, `rr[r]` holds.
- A lane head targets exactly one requester, so each FIFO pops at most once per cycle.
- Simultaneous push and pop on the same FIFO: both take effect, count unchanged.
- Full FIFO with a pop in the same cycle: `lane_ready` is still 0 that cycle (no bypass). The push is accepted next cycle.
- Head-of-line blocking is accepted: a lane blocked on requester r does not expose later entries to other requesters.
- Ordering: responses from one lane to one requester leave in arrival order. No ordering across lanes.
- Out-of-range writeIndex cannot occur, since IDX_W exactly covers LANES.

## Timing
- Latency: a response pushed in cycle N is visible on `req_*` in cycle N+1 at the earliest. There is no combinational lane→req path.
- `req_valid` and payload depend only on registered state.
  - Once `req_valid[r]` is asserted, the grant may change only after a handshake, or because `rr[r]` is unchanged while a higher-priority lane becomes newly valid.
  - Requesters must not rely on payload stability without a handshake.
- Throughput: each requester can complete 1 response per cycle; all LANES requesters can complete concurrently.
- Reset state (reset==0 on an edge):
  - all FIFO counts and pointers 0, `rr[*]`=0;
  - `req_valid`=0, `lane_ready`=all-1 from the first cycle after reset deasserts;
  - `req_data`/`req_dataOffset`/`req_srcLane` read as 0 while `req_valid`=0.
- Reset mid-operation discards all buffered responses. Upstream reissue is the system's responsibility.

## Configuration
- `MASK_UNIT_RESP_PERF_EN` defined:
  - adds output `conflict_cnt` (LANES*16).
  - Per requester: a saturating 16-bit count of cycles where ≥2 lanes were candidates for that requester.
  - Cleared by reset; saturates at 16'hFFFF.
- Undefined: the port and counters are absent; other behaviour is identical.

## Structure
- Package `mask_unit_resp_pkg`:
  - `LANE_IDX_W` helper function;
  - `resp_entry_t` struct `{data, writeIndex, dataOffset}`, parameterized through package localparams that match the module defaults;
  - the `PERF_CNT_W`=16 constant.
- Sub-module `mask_unit_resp_fifo`: one per lane. Single-clock, synchronous active-low reset, count-based full/empty, head exposed combinationally.
- The arbiters stay inline in a generate loop over requesters.

## Test plan
- Reset: hold reset=0 for 3 cycles with all `lane_valid`=1, then release → `req_valid`=0 and `lane_ready`=4'b1111 on the first cycle after release; nothing emerges before one push has occurred.
- Single path: lane 2 sends data 32'hA5A5_0001, writeIndex 1, offset 2 → next cycle `req_valid`=4'b0010, `req_data[1]`=A5A5_0001, `req_srcLane[1]`=2, `req_dataOffset[1]`=2.
- Conflict: lanes 0–3 all target requester 0 in the same cycle with `req_ready[0]`=1 → requester 0 serves srcLane 0,1,2,3 on 4 consecutive cycles. With PERF_EN, `conflict_cnt[0]`=3.
- Backpressure: `req_ready`=0, lane 1 pushes 3 responses → `lane_ready[1]`=0 after 2 pushes; the third is held until a pop. Raising `req_ready` then delivers all 3 in order.
- Full crossbar: lane i targets requester (i+1)%4 every cycle with all ready → 4 responses/cycle sustained; `lane_ready` stays 1.
- Reset mid-stream: assert reset with 2 entries buffered in lane 3 → after release, `req_valid`=0 and no stale data emerges.
